// File: rtl/dxm_sync_multi.sv
// Multi-channel asynchronous-input conditioner: per-bit synchroniser, optional glitch filter
// (DXM_SYNC_MULTI_FILTER_EN) and registered rise/fall/any_change pulses.
module dxm_sync_multi #(
  parameter int               width    = 4,
  parameter int               stages   = 2,
  parameter int               filt_cnt = 4,
  parameter logic [width-1:0] rst_val  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] in,
  output logic [width-1:0] out,
  output logic [width-1:0] rise_pulse,
  output logic [width-1:0] fall_pulse,
  output logic             any_change
);

  generate
    if (stages < 2 || filt_cnt < 1) begin : g_param_err
      $fatal(1, "dxm_sync_multi: stages must be >= 2 and filt_cnt >= 1");
    end
  endgenerate

  // Without the filter, out itself is the last synchroniser flop.
`ifdef DXM_SYNC_MULTI_FILTER_EN
  localparam int chain_len = (stages < 1) ? 1 : stages;
`else
  localparam int chain_len = (stages < 2) ? 1 : stages - 1;
`endif

  logic [width-1:0] sync_q [chain_len];
  logic [width-1:0] sync_d [chain_len];
  logic [width-1:0] out_q, out_d;
  logic [width-1:0] rise_q, rise_d;
  logic [width-1:0] fall_q, fall_d;
  logic             any_q, any_d;

  always_comb begin
    sync_d[0] = in;
    for (int s = 1; s < chain_len; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < chain_len; s++) begin
        sync_q[s] <= rst_val;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef DXM_SYNC_MULTI_FILTER_EN
  localparam int cnt_w = $clog2(filt_cnt + 1);

  logic [width-1:0] tail;
  logic [cnt_w-1:0] cnt_q [width];
  logic [cnt_w-1:0] cnt_d [width];

  assign tail = sync_q[chain_len-1];

  // A differing tail must persist for filt_cnt consecutive samples before out follows.
  always_comb begin
    out_d = out_q;
    for (int i = 0; i < width; i++) begin
      cnt_d[i] = '0;
      if (tail[i] != out_q[i]) begin
        if (cnt_q[i] == cnt_w'(filt_cnt - 1)) begin
          out_d[i] = tail[i];
        end else begin
          cnt_d[i] = cnt_q[i] + cnt_w'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < width; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    out_d = sync_q[chain_len-1];
  end
`endif

  always_comb begin
    rise_d = out_d & ~out_q;
    fall_d = ~out_d & out_q;
    any_d  = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= rst_val;
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= any_d;
    end
  end

  assign out        = out_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign any_change = any_q;

endmodule

// File: tb/tb_dxm_sync_multi.sv
// Bench for dxm_sync_multi: history-based reference model feeding an expected-value queue,
// plus a second instance with a non-zero reset value.
module tb_dxm_sync_multi;

  localparam int W = 4;
  localparam int S = 2;
  localparam int F = 4;
  localparam logic [W-1:0] RV  = 4'h0;
  localparam logic [W-1:0] RVA = 4'hA;
`ifdef DXM_SYNC_MULTI_FILTER_EN
  localparam int LAT = S + F;
  localparam int GLITCH_RISES = 0;
  localparam int TOGGLE_PULSES = 0;
`else
  localparam int LAT = S;
  localparam int GLITCH_RISES = 1;
  localparam int TOGGLE_PULSES = 20;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_s, out_s, rise_s, fall_s;
  logic         any_s;
  logic [W-1:0] in_a, out_a, rise_a, fall_a;
  logic         any_a;

  int passed = 0;
  int total  = 0;
  logic a_moved = 1'b0;

  logic [3*W:0] exp_q[$];

  // reference model state
  logic [W-1:0] m_sh [S];
  logic [W-1:0] m_hist [F];
  logic [W-1:0] m_out, m_rise, m_fall;
  logic         m_any;

  dxm_sync_multi #(.width(W), .stages(S), .filt_cnt(F), .rst_val(RV)) u_dut (
    .clk(clk), .rst_n(rst_n), .in(in_s), .out(out_s),
    .rise_pulse(rise_s), .fall_pulse(fall_s), .any_change(any_s)
  );

  dxm_sync_multi #(.width(W), .stages(S), .filt_cnt(F), .rst_val(RVA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .out(out_a),
    .rise_pulse(rise_a), .fall_pulse(fall_a), .any_change(any_a)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < S; k++) m_sh[k] = RV;
    for (int k = 0; k < F; k++) m_hist[k] = RV;
    m_out  = RV;
    m_rise = '0;
    m_fall = '0;
    m_any  = 1'b0;
  endtask

  task automatic model_edge();
    logic [W-1:0] nxt;
    logic         all_diff;
    if (!rst_n) begin
      model_reset();
    end else begin
`ifdef DXM_SYNC_MULTI_FILTER_EN
      for (int k = F - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_sh[S-1];
      nxt = m_out;
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        for (int k = 0; k < F; k++) if (m_hist[k][b] == m_out[b]) all_diff = 1'b0;
        if (all_diff) nxt[b] = ~m_out[b];
      end
      for (int k = S - 1; k > 0; k--) m_sh[k] = m_sh[k-1];
      m_sh[0] = in_s;
`else
      for (int k = S - 1; k > 0; k--) m_sh[k] = m_sh[k-1];
      m_sh[0] = in_s;
      nxt = m_sh[S-1];
`endif
      m_rise = nxt & ~m_out;
      m_fall = ~nxt & m_out;
      m_any  = |(m_rise | m_fall);
      m_out  = nxt;
    end
  endtask

  task automatic step();
    logic [3*W:0] exp;
    @(posedge clk);
    model_edge();
    exp_q.push_back({m_out, m_rise, m_fall, m_any});
    #1;
    exp = exp_q.pop_front();
    total++;
    if ({out_s, rise_s, fall_s, any_s} !== exp)
      $display("FAIL model_cycle t=%0t got out/rise/fall/any=%h/%h/%h/%b want %h/%h/%h/%b",
               $time, out_s, rise_s, fall_s, any_s, exp[3*W:2*W+1], exp[2*W:W+1], exp[W:1], exp[0]);
    else passed++;
    if (!a_moved) begin
      total++;
      if ({out_a, any_a} !== {RVA, 1'b0})
        $display("FAIL rstval_hold t=%0t got out=%h any=%b want out=%h any=0", $time, out_a, any_a, RVA);
      else passed++;
    end
  endtask

  task automatic drive(input logic [W-1:0] v);
    @(negedge clk);
    in_s = v;
  endtask

  task automatic test_reset();
    int lat = 0;
    int rises = 0;
    rst_n = 1'b0;
    in_s  = 4'hF;
    in_a  = RVA;
    model_reset();
    repeat (4) step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (out_s == 4'hF && lat == 0) lat = n;
      if (rise_s == 4'hF && any_s) rises++;
    end
    total++;
    if (lat !== LAT) $display("FAIL reset_latency got %0d want %0d", lat, LAT); else passed++;
    total++;
    if (rises !== 1) $display("FAIL reset_rise_count got %0d want 1", rises); else passed++;
  endtask

  task automatic test_glitch();
    int rises = 0;
    int lat = 0;
    drive(4'h0);
    repeat (12) step();
    drive(4'h1);
    for (int n = 0; n < 3; n++) begin step(); if (rise_s[0]) rises++; end
    drive(4'h0);
    for (int n = 0; n < 12; n++) begin step(); if (rise_s[0]) rises++; end
    total++;
    if (rises !== GLITCH_RISES) $display("FAIL glitch_rises got %0d want %0d", rises, GLITCH_RISES);
    else passed++;
    rises = 0;
    drive(4'h1);
    for (int n = 1; n <= 20; n++) begin
      step();
      if (out_s[0] && lat == 0) lat = n;
      if (rise_s[0]) rises++;
    end
    total++;
    if (lat !== LAT) $display("FAIL glitch_hold_latency got %0d want %0d", lat, LAT); else passed++;
    total++;
    if (rises !== 1) $display("FAIL glitch_hold_rises got %0d want 1", rises); else passed++;
  endtask

  task automatic test_independence();
    int anys = 0;
    logic [W-1:0] r = '0;
    logic [W-1:0] f = '0;
    drive(4'h5);
    repeat (12) step();
    drive(4'hA);
    for (int n = 0; n < 15; n++) begin
      step();
      if (any_s) begin anys++; r = rise_s; f = fall_s; end
    end
    total++;
    if (anys !== 1) $display("FAIL indep_any_count got %0d want 1", anys); else passed++;
    total++;
    if ({r, f} !== {4'hA, 4'h5}) $display("FAIL indep_pulses got rise=%h fall=%h want rise=a fall=5", r, f);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat = 0;
    drive(4'h0);
    repeat (12) step();
    drive(4'h4);
    repeat (4) step();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({out_s, rise_s, fall_s, any_s} !== 13'h0)
      $display("FAIL mid_reset_async got out=%h rise=%h fall=%h any=%b want all 0", out_s, rise_s, fall_s, any_s);
    else passed++;
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (out_s[2] && lat == 0) lat = n;
    end
    total++;
    if (lat !== LAT) $display("FAIL mid_reset_latency got %0d want %0d", lat, LAT); else passed++;
  endtask

  task automatic test_toggle();
    int pulses = 0;
    drive(4'h0);
    repeat (12) step();
    for (int n = 0; n < 20; n++) begin
      drive(in_s ^ 4'h2);
      step();
      if (rise_s[1] || fall_s[1]) pulses++;
    end
    for (int n = 0; n < 12; n++) begin
      step();
      if (rise_s[1] || fall_s[1]) pulses++;
    end
    total++;
    if (pulses !== TOGGLE_PULSES) $display("FAIL toggle_pulses got %0d want %0d", pulses, TOGGLE_PULSES);
    else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 120; n++) begin
      drive(4'($urandom_range(0, 15)));
      repeat ($urandom_range(1, 6)) step();
    end
    repeat (12) step();
  endtask

  task automatic test_rst_val();
    int lat = 0;
    int anys = 0;
    logic [W-1:0] r = '0;
    logic [W-1:0] f = '0;
    @(negedge clk);
    a_moved = 1'b1;
    in_a = 4'h5;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (out_a == 4'h5 && lat == 0) lat = n;
      if (any_a) begin anys++; r = rise_a; f = fall_a; end
    end
    total++;
    if (lat !== LAT) $display("FAIL rstval_latency got %0d want %0d", lat, LAT); else passed++;
    total++;
    if (anys !== 1) $display("FAIL rstval_any_count got %0d want 1", anys); else passed++;
    total++;
    if ({r, f} !== {4'h5, 4'hA}) $display("FAIL rstval_pulses got rise=%h fall=%h want rise=5 fall=a", r, f);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_independence();
    test_reset_mid();
    test_toggle();
    test_random();
    test_rst_val();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
